// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard / halt controller.
// The HAZARD_ZERO_REG_EN macro, when defined, makes register 0 a hardwired zero
// that never creates a hazard.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [3:0] HLT_OP_DEF = 4'hF;

  // Ceiling log2. Returns 0 for v <= 1; callers clamp to a minimum width.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of the cycles a load result is still unavailable.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt;

  // A new load wins over the running countdown of an older one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (set)        cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage load-use hazard detection, halt FSM and stall performance counter.
// Optional feature: HAZARD_ZERO_REG_EN (register 0 hardwired to zero).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int              REG_W    = 4,
  parameter int              OP_W     = 4,
  parameter logic [OP_W-1:0] HLT_OP   = OP_W'(HLT_OP_DEF),
  parameter int              LOAD_LAT = 1,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_mr,
  input  logic             id_ex_valid,
  input  logic             flush,
  input  logic             resume,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DEPTH = 2 ** REG_W;
  // LOAD_LAT=0 would give a zero-width counter; one bit is kept and never set nonzero.
  localparam int SB_W  = (clog2(LOAD_LAT + 1) < 1) ? 1 : clog2(LOAD_LAT + 1);
  localparam logic [SB_W-1:0] LAT_V = SB_W'(LOAD_LAT);

`ifdef HAZARD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_e           state;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] busy;
  logic             rs_ok;
  logic             rt_ok;
  logic             ld_ok;
  logic             is_load;
  logic             hz_load;
  logic             hz_sb;
  logic             is_hlt;
  logic             detect;

  // r0 sources and destinations drop out of hazard tracking when it is hardwired zero.
  assign rs_ok   = !ZERO_REG || (if_id_rs != '0);
  assign rt_ok   = !ZERO_REG || (if_id_rt != '0);
  assign ld_ok   = !ZERO_REG || (id_ex_rt != '0);
  assign is_load = id_ex_valid && id_ex_mr;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_sb
      assign set_vec[i] = is_load && ld_ok && (id_ex_rt == REG_W'(i));
      hazard_sb_entry #(.CW(SB_W)) u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set_vec[i]),
        .load_val (LAT_V),
        .busy     (busy[i])
      );
    end
  endgenerate

  assign hz_load = is_load && ((rs_ok && (id_ex_rt == if_id_rs)) ||
                               (rt_ok && (id_ex_rt == if_id_rt)));
  assign hz_sb   = (rs_ok && busy[if_id_rs]) || (rt_ok && busy[if_id_rt]);
  assign is_hlt  = (opcode == HLT_OP);

  // Flush outranks every stall source: a wrong-path instruction must never hold the pipe.
  always_comb begin
    detect = is_hlt || hz_load || hz_sb;
    if (state == HALT) detect = 1'b1;
  end

  assign stall       = detect && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign halted      = (state == HALT);

  // Run/halt FSM; once in HALT only resume leaves, flush has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (is_hlt && !flush) state <= HALT;
        HALT:    if (resume)           state <= RUN;
        default:                       state <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
